// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte FIFO behind the UART receiver with level/watermark/overflow/underflow/character-timeout status.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_dv_i,
  input  logic [7:0]       rx_byte_i,
  input  logic [15:0]      clks_per_bit_i,
  input  logic [7:0]       timeout_bits_i,
  input  logic [LVL_W-1:0] watermark_i,
  input  logic             fifo_clr_i,
  input  logic             rd_en_i,
  output logic [7:0]       rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o,
  output logic             watermark_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             timeout_o
);
  localparam int PW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   cyc_cnt, cpb_m1;
  logic [7:0]    bit_cnt;
  logic          push, pop, hold, tc;
  always_comb begin
    empty_o     = level_o == '0;
    full_o      = level_o == LVL_W'(DEPTH);
    watermark_o = (watermark_i != '0) && (level_o >= watermark_i);
    rd_data_o   = mem[rd_ptr];
    pop         = rd_en_i & ~empty_o;
    push        = rx_dv_i & (~full_o | pop);
    hold        = empty_o | push | pop | fifo_clr_i | (timeout_bits_i == '0);
    cpb_m1      = (clks_per_bit_i == '0) ? '0 : clks_per_bit_i - 16'd1;
    tc          = cyc_cnt >= cpb_m1;
  end
  always_ff @(posedge clk_i)
    if (push && !fifo_clr_i) mem[wr_ptr] <= rx_byte_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (fifo_clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) level_o <= level_o + 1'b1;
      else if (pop && !push) level_o <= level_o - 1'b1;
      if (rx_dv_i && full_o && !pop) overflow_o <= 1'b1;
      if (rd_en_i && empty_o) underflow_o <= 1'b1;
    end
  end
  // cyc_cnt measures one bit time; bit_cnt counts idle bit times while data sits unread
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (hold) begin
        cyc_cnt <= '0;
        bit_cnt <= '0;
      end else if (tc) begin
        cyc_cnt <= '0;
        bit_cnt <= (bit_cnt == 8'hFF) ? bit_cnt : bit_cnt + 8'd1;
      end else begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
      if (fifo_clr_i || push || pop) timeout_o <= 1'b0;
      else if (timeout_bits_i != '0 && !empty_o && bit_cnt == timeout_bits_i) timeout_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with a byte scoreboard checked on every pop, plus direct status checks.
module tb_uart_rx_fifo;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_dv_i = 1'b0;
  logic [7:0] rx_byte_i = '0;
  logic [15:0] clks_per_bit_i = 16'd10;
  logic [7:0] timeout_bits_i = '0;
  logic [4:0] watermark_i = '0;
  logic       fifo_clr_i = 1'b0;
  logic       rd_en_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       empty_o, full_o, watermark_o, overflow_o, underflow_o, timeout_o;
  logic [4:0] level_o;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_dv_i(rx_dv_i), .rx_byte_i(rx_byte_i),
    .clks_per_bit_i(clks_per_bit_i), .timeout_bits_i(timeout_bits_i),
    .watermark_i(watermark_i), .fifo_clr_i(fifo_clr_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .empty_o(empty_o), .full_o(full_o), .level_o(level_o),
    .watermark_o(watermark_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && rd_en_i && !empty_o && !fifo_clr_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_pop: got %0h expected nothing (scoreboard empty)", rd_data_o);
      end else begin
        check("sb_pop", int'(rd_data_o), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    rx_dv_i = 1'b1;
    rx_byte_i = b;
    if (acc) exp_q.push_back(b);
    cyc();
    rx_dv_i = 1'b0;
  endtask

  task automatic pop();
    rd_en_i = 1'b1;
    cyc();
    rd_en_i = 1'b0;
  endtask

  task automatic clr();
    fifo_clr_i = 1'b1;
    exp_q.delete();
    cyc();
    fifo_clr_i = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_empty", empty_o, 1);
    check("rst_level", level_o, 0);
    check("rst_full", full_o, 0);
    check("rst_flags", {overflow_o, underflow_o, timeout_o}, 0);
    rst_ni = 1'b1;
    cyc();
    push(8'hA5, 1);
    check("fwft_data", rd_data_o, 8'hA5);
    check("fwft_empty", empty_o, 0);
    push(8'h3C, 1);
    check("level2", level_o, 2);
    pop();
    check("level1", level_o, 1);
    check("head_3c", rd_data_o, 8'h3C);
    pop();
    check("empty_again", empty_o, 1);

    for (int i = 0; i < 16; i++) push(8'(i), 1);
    check("full", full_o, 1);
    check("level16", level_o, 16);
    push(8'hFF, 0);
    check("overflow_set", overflow_o, 1);
    check("level_kept", level_o, 16);
    for (int i = 0; i < 16; i++) pop();
    check("drained", empty_o, 1);
    push(8'h10, 1);
    check("wrap_data", rd_data_o, 8'h10);
    pop();
    check("no_underflow", underflow_o, 0);
    pop();
    check("underflow_set", underflow_o, 1);
    clr();
    check("clr_flags", {overflow_o, underflow_o}, 0);

    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1);
    rd_en_i = 1'b1;
    push(8'h77, 1);
    rd_en_i = 1'b0;
    check("pushpop_full_level", level_o, 16);
    check("pushpop_full_ovf", overflow_o, 0);
    for (int i = 0; i < 15; i++) pop();
    check("pushpop_tail", rd_data_o, 8'h77);
    pop();
    check("empty3", empty_o, 1);

    watermark_i = 5'd4;
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 1);
    check("wm_3", watermark_o, 0);
    push(8'h33, 1);
    check("wm_4", watermark_o, 1);
    pop();
    check("wm_pop", watermark_o, 0);
    push(8'h34, 1);
    check("wm_4b", watermark_o, 1);
    watermark_i = 5'd0;
    #1;
    check("wm_dis", watermark_o, 0);
    for (int i = 0; i < 4; i++) pop();

    clks_per_bit_i = 16'd10;
    timeout_bits_i = 8'd4;
    push(8'h55, 1);
    for (int i = 0; i < 40; i++) cyc();
    check("to_early", timeout_o, 0);
    cyc();
    check("to_set", timeout_o, 1);
    pop();
    check("to_clr_pop", timeout_o, 0);
    timeout_bits_i = 8'd0;
    push(8'h56, 1);
    for (int i = 0; i < 1000; i++) cyc();
    check("to_disabled", timeout_o, 0);
    pop();

    pop();
    check("uf2", underflow_o, 1);
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1);
    push(8'h99, 0);
    check("ovf2", overflow_o, 1);
    for (int i = 0; i < 11; i++) pop();
    check("level5", level_o, 5);
    clks_per_bit_i = 16'd2;
    timeout_bits_i = 8'd1;
    for (int i = 0; i < 10; i++) cyc();
    check("to2", timeout_o, 1);
    rx_dv_i = 1'b1;
    rx_byte_i = 8'hEE;
    clr();
    rx_dv_i = 1'b0;
    check("clr_level", level_o, 0);
    check("clr_empty", empty_o, 1);
    check("clr_sticky", {overflow_o, underflow_o, timeout_o}, 0);
    timeout_bits_i = 8'd0;

    push(8'h01, 1);
    push(8'h02, 1);
    rx_dv_i = 1'b1;
    rx_byte_i = 8'h03;
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("arst_level", level_o, 0);
    check("arst_empty", empty_o, 1);
    check("arst_full", full_o, 0);
    rx_dv_i = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();
    check("post_rst_empty", empty_o, 1);
    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
